// File: rtl/book_snapshot_tx_if.sv
// Stream bus carrying book snapshot beats from the transmitter to the host/DMA path.
// Each beat is a 64-bit payload with valid/ready flow control and an end-of-frame marker.
interface book_snapshot_tx_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/book_snapshot_tx.sv
// Bid-side order book snapshot transmitter.
// A request freezes all N levels. The frame is one header beat followed by one
// {price,quantity} beat per non-empty level, in ascending level order.
// One request that arrives mid-frame is queued; any further ones are counted as dropped.
module book_snapshot_tx #(
  parameter int          N     = 10,
  parameter logic [15:0] MAGIC = 16'hB00C,
  parameter int          CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0][31:0]   bidprices_in,
  input  logic [N-1:0][31:0]   bidquantities_in,
  input  logic                 snap_req,
  book_snapshot_tx_if.master   master,
  output logic                 busy,
  output logic [CNT_W-1:0]     dropped_reqs
);

  typedef enum logic [1:0] {IDLE, HDR, LVL} state_t;

  state_t               state_q, state_d;
  logic [N-1:0][31:0]   price_q, price_d;
  logic [N-1:0][31:0]   qty_q, qty_d;
  logic [N-1:0]         mask_q, mask_d;
  logic [3:0]           count_q, count_d;
  logic [3:0]           ptr_q, ptr_d;
  logic [15:0]          seq_q, seq_d;
  logic                 pending_q, pending_d;
  logic [CNT_W-1:0]     dropped_q, dropped_d;
  logic [63:0]          tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic                 busy_q, busy_d;

  logic [N-1:0]         live_mask;
  logic [3:0]           live_count;
  logic                 handshake;
  logic                 final_hs;
  logic                 start;

  function automatic logic [3:0] lowest_idx(input logic [N-1:0] m);
    lowest_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = 4'(i);
    end
  endfunction

  function automatic logic [3:0] highest_idx(input logic [N-1:0] m);
    highest_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) highest_idx = 4'(i);
    end
  endfunction

  function automatic logic [3:0] popcount(input logic [N-1:0] m);
    popcount = '0;
    for (int i = 0; i < N; i++) begin
      popcount = popcount + {3'b000, m[i]};
    end
  endfunction

  // Next state, next latched book and next registered outputs in one place.
  always_comb begin
    state_d   = state_q;
    price_d   = price_q;
    qty_d     = qty_q;
    mask_d    = mask_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    seq_d     = seq_q;
    pending_d = pending_q;
    dropped_d = dropped_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;

    for (int i = 0; i < N; i++) begin
      live_mask[i] = (bidquantities_in[i] != 32'd0);
    end
    live_count = popcount(live_mask);

    handshake = tvalid_q && master.tready;
    final_hs  = handshake && tlast_q;
    start     = ((state_q == IDLE) && snap_req) ||
                (final_hs && (pending_q || snap_req));

    // The sequence number advances when a header is accepted. A back-to-back
    // header that follows a header-only frame must already carry the new value.
    if ((state_q == HDR) && handshake) seq_d = seq_q + 16'd1;

    if (start) begin
      price_d   = bidprices_in;
      qty_d     = bidquantities_in;
      mask_d    = live_mask;
      count_d   = live_count;
      pending_d = 1'b0;
      state_d   = HDR;
      tvalid_d  = 1'b1;
      tlast_d   = (live_count == 4'd0);
      tdata_d   = {MAGIC, seq_d, 28'd0, live_count};
    end else begin
      if (snap_req && (state_q != IDLE)) begin
        if (!pending_q) begin
          pending_d = 1'b1;
        end else if (dropped_q != {CNT_W{1'b1}}) begin
          dropped_d = dropped_q + CNT_W'(1);
        end
      end

      case (state_q)
        HDR: begin
          if (handshake) begin
            if (count_q != 4'd0) begin
              state_d = LVL;
              ptr_d   = lowest_idx(mask_q);
              tdata_d = {price_q[ptr_d], qty_q[ptr_d]};
              tlast_d = (ptr_d == highest_idx(mask_q));
            end else begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
            end
          end
        end
        LVL: begin
          if (handshake) begin
            mask_d[ptr_q] = 1'b0;
            if (tlast_q) begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
            end else begin
              ptr_d   = lowest_idx(mask_d);
              tdata_d = {price_q[ptr_d], qty_q[ptr_d]};
              tlast_d = (ptr_d == highest_idx(mask_d));
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State, latched snapshot and all outputs are registered; reset abandons any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      price_q   <= '0;
      qty_q     <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      ptr_q     <= '0;
      seq_q     <= '0;
      pending_q <= 1'b0;
      dropped_q <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      price_q   <= price_d;
      qty_q     <= qty_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      ptr_q     <= ptr_d;
      seq_q     <= seq_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      busy_q    <= busy_d;
    end
  end

  assign master.tdata  = tdata_q;
  assign master.tvalid = tvalid_q;
  assign master.tlast  = tlast_q;
  assign busy          = busy_q;
  assign dropped_reqs  = dropped_q;

endmodule

// File: tb/tb_book_snapshot_tx.sv
// Self-checking bench for book_snapshot_tx: a transaction-level model builds each
// expected frame from the live book at request time, and a monitor pops and compares beats.
module tb_book_snapshot_tx;

  localparam int          N     = 10;
  localparam int          CNT_W = 8;
  localparam logic [15:0] MAGIC = 16'hB00C;
  localparam int          DROP_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0][31:0]   prices;
  logic [N-1:0][31:0]   qtys;
  logic                 snap_req;
  logic                 busy;
  logic [CNT_W-1:0]     dropped;

  book_snapshot_tx_if bus();

  book_snapshot_tx #(.N(N), .MAGIC(MAGIC), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .bidprices_in     (prices),
    .bidquantities_in (qtys),
    .snap_req         (snap_req),
    .master           (bus),
    .busy             (busy),
    .dropped_reqs     (dropped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [64:0] exp_q[$];
  bit          m_busy;
  bit          m_pending;
  int          m_dropped;
  logic [15:0] m_seq;
  int          beats_left;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Builds the whole expected frame from the book as it stands at the request.
  function automatic int push_frame(input logic [N-1:0][31:0] p, input logic [N-1:0][31:0] q,
                                    input logic [15:0] seq);
    int cnt = 0;
    int hi  = -1;
    for (int i = 0; i < N; i++) begin
      if (q[i] != 0) begin
        cnt++;
        hi = i;
      end
    end
    exp_q.push_back({(cnt == 0), MAGIC, seq, 28'd0, 4'(cnt)});
    for (int i = 0; i < N; i++) begin
      if (q[i] != 0) exp_q.push_back({(i == hi), p[i], q[i]});
    end
    return cnt + 1;
  endfunction

  // Reference model: tracks frame occupancy, the single queued request and drops.
  always @(negedge clk) begin
    bit hs;
    if (rst) begin
      exp_q.delete();
      m_busy     = 1'b0;
      m_pending  = 1'b0;
      m_dropped  = 0;
      m_seq      = 16'd0;
      beats_left = 0;
      checkOutput("reset_tvalid", 64'(bus.tvalid), 64'd0);
      checkOutput("reset_tlast", 64'(bus.tlast), 64'd0);
      checkOutput("reset_tdata", bus.tdata, 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_dropped", 64'(dropped), 64'd0);
    end else begin
      checkOutput("busy", 64'(busy), 64'(m_busy));
      checkOutput("tvalid_vs_busy", 64'(bus.tvalid), 64'(m_busy));
      checkOutput("dropped", 64'(dropped), 64'(m_dropped));
      hs = bus.tvalid && bus.tready;
      if (!m_busy) begin
        if (snap_req) begin
          beats_left = push_frame(prices, qtys, m_seq);
          m_seq++;
          m_busy = 1'b1;
        end
      end else begin
        if (hs) beats_left--;
        if (hs && beats_left == 0) begin
          if (m_pending || snap_req) begin
            beats_left = push_frame(prices, qtys, m_seq);
            m_seq++;
            m_pending = 1'b0;
          end else begin
            m_busy = 1'b0;
          end
        end else if (snap_req) begin
          if (!m_pending) m_pending = 1'b1;
          else if (m_dropped < DROP_MAX) m_dropped++;
        end
      end
    end
  end

  // Monitor: compares every accepted beat and checks stall stability.
  logic        stall_prev = 1'b0;
  logic [63:0] data_prev;
  logic        last_prev;

  always @(negedge clk) begin
    logic [64:0] e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("hold_tvalid", 64'(bus.tvalid), 64'd1);
        checkOutput("hold_tdata", bus.tdata, data_prev);
        checkOutput("hold_tlast", 64'(bus.tlast), 64'(last_prev));
      end
      if (bus.tvalid && bus.tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_beat: got %h expected no beat", bus.tdata);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_tdata", bus.tdata, e[63:0]);
          checkOutput("beat_tlast", 64'(bus.tlast), 64'(e[64]));
        end
      end
      stall_prev = bus.tvalid && !bus.tready;
      data_prev  = bus.tdata;
      last_prev  = bus.tlast;
    end
  end

  task automatic applyStimulus(input logic req, input logic rdy);
    @(posedge clk);
    #1;
    snap_req  = req;
    bus.tready = rdy;
  endtask

  task automatic pulse_req(input logic rdy);
    applyStimulus(1'b1, rdy);
    applyStimulus(1'b0, rdy);
  endtask

  task automatic random_book(input int empty_pct);
    for (int i = 0; i < N; i++) begin
      prices[i] = $urandom;
      qtys[i]   = ($urandom_range(99, 0) < empty_pct) ? 32'd0 : 32'($urandom_range(5000, 1));
    end
  endtask

  // Waits for the model to drain; mode 1 toggles tready as 1,0,0,1,0,0,...
  task automatic wait_idle(input int limit, input int mode);
    int n = 0;
    while ((m_busy || exp_q.size() != 0) && n < limit) begin
      bus.tready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      @(posedge clk);
      #1;
      n++;
    end
    bus.tready = 1'b1;
    total++;
    if (n >= limit) begin
      bad++;
      $display("[TB] FAIL drain_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  initial begin
    bit found;
    rst        = 1'b1;
    snap_req   = 1'b0;
    bus.tready = 1'b1;
    prices     = '0;
    qtys       = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed three-level frame");
    prices[0] = 32'd100; qtys[0] = 32'd5;
    prices[1] = 32'd99;  qtys[1] = 32'd7;
    prices[2] = 32'd98;  qtys[2] = 32'd1;
    pulse_req(1'b1);
    wait_idle(50, 0);
    checkOutput("busy_after_frame", 64'(busy), 64'd0);

    $display("[TB] empty book frame");
    qtys = '0;
    pulse_req(1'b1);
    wait_idle(50, 0);

    $display("[TB] sparse book, inputs changed mid-frame");
    random_book(100);
    qtys[3] = 32'd11;
    qtys[9] = 32'd22;
    pulse_req(1'b1);
    random_book(30);
    wait_idle(50, 0);

    $display("[TB] backpressure");
    random_book(20);
    pulse_req(1'b1);
    wait_idle(200, 1);

    $display("[TB] three requests while busy");
    random_book(0);
    pulse_req(1'b0);
    repeat (3) pulse_req(1'b0);
    wait_idle(200, 0);
    checkOutput("dropped_after_three", 64'(dropped), 64'd2);

    $display("[TB] request on final-beat cycle");
    random_book(40);
    qtys[0] = 32'd9;
    pulse_req(1'b1);
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.tvalid && bus.tlast) begin
        snap_req = 1'b1;
        @(posedge clk);
        #1 snap_req = 1'b0;
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("final_beat_found", 64'(found), 64'd1);
    wait_idle(100, 0);
    checkOutput("dropped_unchanged", 64'(dropped), 64'd2);

    $display("[TB] reset during stalled level beat");
    random_book(100);
    qtys[0] = 32'd1; qtys[1] = 32'd2; qtys[2] = 32'd3;
    pulse_req(1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pre_reset_tvalid", 64'(bus.tvalid), 64'd1);
    checkOutput("pre_reset_tdata", bus.tdata, {prices[1], qtys[1]});
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_tvalid", 64'(bus.tvalid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.tready = 1'b1;
    checkOutput("post_reset_busy", 64'(busy), 64'd0);
    pulse_req(1'b1);
    checkOutput("post_reset_header", bus.tdata[63:32], {MAGIC, 16'h0000});
    wait_idle(50, 0);

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      random_book($urandom_range(90, 0));
      applyStimulus(($urandom_range(5, 0) == 0), ($urandom_range(3, 0) != 0));
    end
    snap_req = 1'b0;
    wait_idle(500, 0);

    $display("[TB] dropped counter saturation");
    random_book(0);
    applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 300; c++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("dropped_saturated", 64'(dropped), 64'(DROP_MAX));
    wait_idle(500, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
